// File: rtl/ram_bus_pkg.sv
// Shared types and constants for the shared-bus RAM initiator.
package ram_bus_pkg;
  localparam int RAM_ADDR_W = 3;
  localparam int RAM_DATA_W = 8;
  localparam int WAIT_W     = 4;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // RD_CAP is never entered: read capture is folded into the IDLE entry.
  typedef enum logic [2:0] {
    IDLE, WR_DRIVE, WR_HOLD, TURN, RD_WAIT, RD_CAP
  } state_t;
endpackage

// File: rtl/ram_bus_master_if.sv
// Request/response handshake between a requester and ram_bus_master.
interface ram_bus_master_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_write, rsp_rdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata
  );
endinterface

// File: rtl/ram_bus_pad.sv
// Tri-state driver for the bidirectional RAM data bus.
module ram_bus_pad #(
  parameter int W = 8
) (
  input  logic         drive_en,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  inout  wire  [W-1:0] pad
);
  assign pad   = drive_en ? wdata : {W{1'bz}};
  assign rdata = pad;
endmodule

// File: rtl/ram_bus_master.sv
// Single-request initiator for the shared-bus RAM: write drive/hold, turnaround, read sampling.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W      = RAM_ADDR_W,
  parameter int DATA_W      = RAM_DATA_W,
  parameter int READ_LAT    = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  ram_bus_master_if.master  host,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_rw,
  inout  wire  [DATA_W-1:0] ram_data
);
  state_t              state;
  logic                drive_en;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   bus_in;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                rsp_valid;
  logic                rsp_write;
  logic [DATA_W-1:0]   rsp_rdata;

  ram_bus_pad #(.W(DATA_W)) u_pad (
    .drive_en (drive_en),
    .wdata    (wdata_q),
    .rdata    (bus_in),
    .pad      (ram_data)
  );

  assign host.req_ready = (state == IDLE) && !reset;
  assign host.rsp_valid = rsp_valid;
  assign host.rsp_write = rsp_write;
  assign host.rsp_rdata = rsp_rdata;

  // ram_address doubles as the latched request address; all bus controls are registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ram_rw      <= RW_READ;
      drive_en    <= 1'b0;
      ram_address <= '0;
      wdata_q     <= '0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (host.req_valid) begin
            ram_address <= host.req_addr;
            wdata_q     <= host.req_wdata;
            if (host.req_write) begin
              state    <= WR_DRIVE;
              ram_rw   <= RW_WRITE;
              drive_en <= 1'b1;
            end else begin
              state    <= RD_WAIT;
              wait_cnt <= WAIT_W'(READ_LAT - 1);
            end
          end
        end
        WR_DRIVE: state <= WR_HOLD;
        WR_HOLD: begin
          // Release the bus on the same edge that raises rw.
          state    <= TURN;
          ram_rw   <= RW_READ;
          drive_en <= 1'b0;
          wait_cnt <= WAIT_W'(TURN_CYCLES - 1);
        end
        TURN: begin
          if (wait_cnt == '0) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RD_WAIT: begin
          if (wait_cnt == '0) begin
            state     <= IDLE;
            rsp_rdata <= bus_in;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench: default instance plus a READ_LAT=4 / TURN_CYCLES=3 instance, each with a RAM model.
module tb_ram_bus_master;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [2:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clock = ~clock;

  ram_bus_master_if #(.ADDR_W(3), .DATA_W(8)) bus1 ();
  ram_bus_master_if #(.ADDR_W(3), .DATA_W(8)) bus2 ();

  logic [2:0] ram_address1, ram_address2;
  logic       ram_rw1, ram_rw2;
  wire  [7:0] ram_data1, ram_data2;
  logic [7:0] mem1 [8];
  logic [7:0] mem2 [8];

  assign bus1.req_valid = req_valid & ~sel;
  assign bus1.req_write = req_write;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus2.req_valid = req_valid & sel;
  assign bus2.req_write = req_write;
  assign bus2.req_addr  = req_addr;
  assign bus2.req_wdata = req_wdata;

  logic       o_ready, o_rsp_valid, o_rsp_write;
  logic [7:0] o_rsp_rdata;
  assign o_ready     = sel ? bus2.req_ready : bus1.req_ready;
  assign o_rsp_valid = sel ? bus2.rsp_valid : bus1.rsp_valid;
  assign o_rsp_write = sel ? bus2.rsp_write : bus1.rsp_write;
  assign o_rsp_rdata = sel ? bus2.rsp_rdata : bus1.rsp_rdata;

  ram_bus_master dut1 (
    .clock(clock), .reset(reset), .host(bus1),
    .ram_address(ram_address1), .ram_rw(ram_rw1), .ram_data(ram_data1)
  );

  ram_bus_master #(.READ_LAT(4), .TURN_CYCLES(3)) dut2 (
    .clock(clock), .reset(reset), .host(bus2),
    .ram_address(ram_address2), .ram_rw(ram_rw2), .ram_data(ram_data2)
  );

  // RAM models: drive the bus while rw=1, write on edges where rw=0.
  assign ram_data1 = ram_rw1 ? mem1[ram_address1] : 8'bz;
  assign ram_data2 = ram_rw2 ? mem2[ram_address2] : 8'bz;
  always @(posedge clock) begin
    if (!ram_rw1) mem1[ram_address1] <= ram_data1;
    if (!ram_rw2) mem2[ram_address2] <= ram_data2;
  end

  // Advance to the next falling edge and check the master never drives while rw is high.
  task automatic tick();
    @(negedge clock);
    n_tests++;
    if ((dut1.drive_en && ram_rw1) || (dut2.drive_en && ram_rw2)) begin
      n_fail++;
      $display("FAIL drive_with_rw_high: en1=%0b rw1=%0b en2=%0b rw2=%0b required en=0 when rw=1",
               dut1.drive_en, ram_rw1, dut2.drive_en, ram_rw2);
    end
  endtask

  // Issue one request from the current (non-edge) time; lat = cycle index of rsp_valid.
  task automatic do_req(input logic w, input logic [2:0] a, input logic [7:0] d, output int lat);
    int n = 0;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!o_ready && n < 50) begin tick(); n++; end
    @(posedge clock); #1 req_valid = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!o_rsp_valid && lat < 60);
  endtask

  task automatic test_reset();
    tick();
    n_tests++;
    if ({ram_rw1, dut1.drive_en, ram_address1, o_rsp_valid, o_ready} !== 7'b1_0_000_0_0) begin
      n_fail++;
      $display("FAIL reset_state: got rw/en/addr/rsp_valid/ready=%b required 1_0_000_0_0",
               {ram_rw1, dut1.drive_en, ram_address1, o_rsp_valid, o_ready});
    end
    n_tests++;
    if ({o_rsp_write, o_rsp_rdata} !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_rsp: got rsp_write=%0b rdata=%h required 0/00", o_rsp_write, o_rsp_rdata);
    end
    @(posedge clock); #1 reset = 1'b0;
    tick();
    n_tests++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %0b required 1", o_ready);
    end
  endtask

  task automatic test_write_read();
    int lat;
    do_req(1'b1, 3'd3, 8'hA5, lat);
    n_tests++;
    if (lat != 4 || o_rsp_write !== 1'b1) begin
      n_fail++;
      $display("FAIL write_latency: got lat=%0d rsp_write=%0b required 4/1", lat, o_rsp_write);
    end
    do_req(1'b0, 3'd3, 8'h00, lat);
    n_tests++;
    if (lat != 3 || o_rsp_rdata !== 8'hA5 || o_rsp_write !== 1'b0) begin
      n_fail++;
      $display("FAIL read_a5: got lat=%0d rdata=%h rsp_write=%0b required 3/a5/0",
               lat, o_rsp_rdata, o_rsp_write);
    end
    tick();
    n_tests++;
    if (o_rsp_valid !== 1'b0 || o_rsp_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL rdata_hold: got rsp_valid=%0b rdata=%h required 0/a5", o_rsp_valid, o_rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, acc = 0, last = 0, k, lat;
    req_write = 1'b1; req_addr = 3'd0; req_wdata = 8'h10; req_valid = 1'b1;
    while (acc < 8 && n < 200) begin
      if (o_ready) begin
        if (acc > 0) begin
          n_tests++;
          if (!o_rsp_valid || n - last != 4) begin
            n_fail++;
            $display("FAIL b2b_accept: got spacing=%0d rsp_valid=%0b required 4/1", n - last, o_rsp_valid);
          end
        end
        acc++; last = n;
        @(posedge clock); #1;
        if (acc < 8) begin req_addr = 3'(acc); req_wdata = 8'h10 + 8'(acc); end
        else req_valid = 1'b0;
      end
      tick(); n++;
    end
    k = 1;
    while (!o_rsp_valid && k < 20) begin tick(); k++; end
    n_tests++;
    if (acc != 8 || k != 4) begin
      n_fail++;
      $display("FAIL b2b_last: got accepted=%0d last_lat=%0d required 8/4", acc, k);
    end
    for (int a = 7; a >= 0; a--) begin
      do_req(1'b0, 3'(a), 8'h00, lat);
      n_tests++;
      if (lat != 3 || o_rsp_rdata !== 8'h10 + 8'(a)) begin
        n_fail++;
        $display("FAIL b2b_readback addr %0d: got lat=%0d rdata=%h required 3/%h",
                 a, lat, o_rsp_rdata, 8'h10 + 8'(a));
      end
    end
  endtask

  task automatic test_read_blocking();
    int k;
    req_write = 1'b0; req_addr = 3'd2; req_wdata = 8'h00; req_valid = 1'b1;
    @(posedge clock); #1 req_addr = 3'd5;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_tests++;
      if ({o_ready, o_rsp_valid} !== ((c == 3) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL block_cycle%0d: got ready/rsp_valid=%b required %b",
                 c, {o_ready, o_rsp_valid}, (c == 3) ? 2'b11 : 2'b00);
      end
    end
    n_tests++;
    if (o_rsp_rdata !== 8'h12) begin
      n_fail++;
      $display("FAIL block_addr2: got %h required 12", o_rsp_rdata);
    end
    @(posedge clock); #1 req_valid = 1'b0;
    k = 0;
    do begin tick(); k++; end while (!o_rsp_valid && k < 20);
    n_tests++;
    if (k != 3 || o_rsp_rdata !== 8'h15) begin
      n_fail++;
      $display("FAIL block_addr5: got lat=%0d rdata=%h required 3/15", k, o_rsp_rdata);
    end
  endtask

  task automatic test_reset_mid_write();
    int seen = 0;
    req_write = 1'b1; req_addr = 3'd6; req_wdata = 8'h77; req_valid = 1'b1;
    @(posedge clock); #1 req_valid = 1'b0;
    tick();
    @(posedge clock); #1;
    n_tests++;
    if ({ram_rw1, dut1.drive_en} !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_hold_setup: got rw/en=%b required 01", {ram_rw1, dut1.drive_en});
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({ram_rw1, dut1.drive_en, o_ready, ram_address1} !== 6'b100_000) begin
      n_fail++;
      $display("FAIL async_reset: got rw/en/ready/addr=%b required 100000",
               {ram_rw1, dut1.drive_en, o_ready, ram_address1});
    end
    repeat (2) begin tick(); if (o_rsp_valid) seen++; end
    @(posedge clock); #1 reset = 1'b0;
    tick();
    n_tests++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_abort: got %0b required 1", o_ready);
    end
    repeat (5) begin if (o_rsp_valid) seen++; tick(); end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL aborted_rsp: got %0d rsp_valid pulses required 0", seen);
    end
  endtask

  task automatic test_override();
    int lat;
    sel = 1'b1;
    tick();
    do_req(1'b1, 3'd4, 8'h3C, lat);
    n_tests++;
    if (lat != 6 || o_rsp_write !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_write: got lat=%0d rsp_write=%0b required 6/1", lat, o_rsp_write);
    end
    do_req(1'b0, 3'd4, 8'h00, lat);
    n_tests++;
    if (lat != 5 || o_rsp_rdata !== 8'h3C || o_rsp_write !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_read: got lat=%0d rdata=%h rsp_write=%0b required 5/3c/0",
               lat, o_rsp_rdata, o_rsp_write);
    end
    tick();
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_read_blocking();
    test_reset_mid_write();
    test_override();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_bus_master.md
# ram_bus_master

Initiator for the 8-location, 8-bit shared-bus RAM. Accepts single read or write requests over a valid/ready handshake from control logic and sequences the RAM's address, rw and bidirectional data lines. The sequencing includes write drive/hold, bus turnaround, and read sampling. Sits between any requester (test sequencer, CPU stub) and the RAM's pins. Only this block drives the data bus, and only while rw is low.

## Interface
- ADDR_W, 3, RAM address width
- DATA_W, 8, RAM data width
- READ_LAT, 2, cycles ram_address is held with ram_rw=1 before read data is sampled; legal range 1..15
- TURN_CYCLES, 1, idle cycles with bus released after a write before the next request is accepted; legal range 1..15
- clock  in  1  clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; equals (state==IDLE) && !reset
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  target location
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse, for both reads and writes
- rsp_write  out  1  type of the completed request
- rsp_rdata  out  DATA_W  captured read data; holds its last value otherwise
- ram_address  out  ADDR_W  RAM address
- ram_rw  out  1  1=RAM drives bus (read/idle), 0=master drives bus (write)
- ram_data  inout  DATA_W  bidirectional data bus; high-Z unless drive enable is set

## Operation
- States: IDLE, WR_DRIVE, WR_HOLD, TURN, RD_WAIT, RD_CAP.
- IDLE: ram_rw=1, bus released, ram_address holds its last value.
  - Request is accepted on an edge with req_valid && req_ready.
  - On acceptance, latch req_addr, req_wdata and req_write.
  - Next state is WR_DRIVE for a write, RD_WAIT for a read.
- WR_DRIVE (1 cycle): ram_address=addr_q, ram_rw=0, drive ram_data=wdata_q. The RAM writes on the following edge. Next state: WR_HOLD.
- WR_HOLD (1 cycle): same outputs, so data is still stable when rw rises. Next state: TURN.
- TURN (TURN_CYCLES cycles): ram_rw=1, bus released on the same edge that raises rw. Next state: IDLE, with rsp_valid=1 and rsp_write=1.
- RD_WAIT (READ_LAT cycles): ram_address=addr_q, ram_rw=1, bus released.
  - The edge ending the last RD_WAIT cycle samples ram_data into rsp_rdata.
  - Next state: RD_CAP.
- RD_CAP is not a bus cycle. It is the IDLE entry with rsp_valid=1 and rsp_write=0, and is folded into IDLE: req_ready=1 in the same cycle.
- Invariants:
  - Drive enable=1 implies ram_rw=0.
  - Drive enable and ram_rw come from registers; no combinational path from req_* to ram_*.
- Requests are ignored while req_ready=0. The requester holds req_* stable until accepted.
- A wait counter is shared by TURN and RD_WAIT and reloads on state entry. It is 4 bits wide, sized by the max of READ_LAT and TURN_CYCLES.

## Timing
- Reset is asynchronous, forced immediately. Values while asserted:
  - state=IDLE, ram_rw=1, drive enable=0 (bus high-Z), ram_address=0
  - rsp_valid=0, rsp_write=0, rsp_rdata=0, req_ready=0
- Reset mid-operation: bus released and rw raised immediately. The aborted request produces no rsp_valid, and a partial write may or may not have landed.
- req_ready rises in the first cycle after reset deasserts.
- Cycle 0 is the cycle in which the request is accepted.
- Write:
  - cycle 1 is WR_DRIVE, cycle 2 is WR_HOLD
  - cycles 3..2+TURN_CYCLES are TURN
  - rsp_valid in cycle 3+TURN_CYCLES (default 4)
- Read: cycles 1..READ_LAT are RD_WAIT; rsp_valid and valid rsp_rdata in cycle READ_LAT+1 (default 3).
- Back-to-back: a new request may be accepted in the rsp_valid cycle.
  - Sustained write throughput: one per 3+TURN_CYCLES cycles.
  - Sustained read throughput: one per READ_LAT+1 cycles.
- Address wrap-around: none; any ADDR_W value is legal.

## Structure
- Shared package ram_bus_pkg holds:
  - the state enum
  - RAM_ADDR_W=3, RAM_DATA_W=8
  - the ram_rw encoding constants RW_READ=1, RW_WRITE=0
- Sub-module: ram_bus_pad, the tri-state driver for ram_data. It takes the drive enable and write data, and returns sampled bus data.
- FSM, counter and response registers live in ram_bus_master.

## Test plan
- Reset then idle:
  - required: ram_rw=1, ram_data=Z, ram_address=0, rsp_valid=0
  - required: req_ready=1 on the first cycle after reset release
- Write 0xA5 to addr 3, then read addr 3:
  - write rsp_valid in cycle 4
  - read rsp_valid in cycle 3 of the second request, with rsp_rdata=0xA5 and rsp_write=0
  - bus Z in every cycle where ram_rw=1
- Write 8 locations with 0x10+addr back-to-back (req_valid held high), then read 7..0:
  - each readback equals the written value
  - exactly one request accepted per rsp_valid cycle
- req_valid asserted with req_addr=5 during RD_WAIT of a read to addr 2:
  - no acceptance until the rsp_valid cycle
  - addr 2 returns its data, then addr 5 is serviced
- Assert reset in WR_HOLD:
  - ram_data goes Z and ram_rw goes 1 within the same delta/cycle
  - no rsp_valid
  - req_ready returns 1 after release
- Override READ_LAT=4 and TURN_CYCLES=3:
  - read rsp_valid in cycle 5, write rsp_valid in cycle 6
  - an assertion checks drive enable && ram_rw never occurs
